// File: rtl/timer_sched.sv
// timer_sched: shares one timer between NREQ requesters with round-robin arbitration,
// returning a one-cycle DONE to the owner and flagging timers that never pulse.
module timer_sched #(
  parameter int NREQ = 4,
  parameter int TW   = 21
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               SOFT_CLR,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*TW-1:0] REQ_VAL,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    DONE,
  output logic               BUSY,
  output logic               ERR,
  output logic               TMR_START,
  output logic [TW-1:0]      TMR_VAL,
  output logic               TMR_CLR,
  input  logic               TMR_PULSE
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic            clr_q, clr_d;
  logic [TW-1:0]   val_q, val_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [TW:0]     cnt_q, cnt_d;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [PW-1:0]   winner;
  logic [TW-1:0]   winVal;
  logic [PW-1:0]   nextPtr;
  logic [TW:0]     cntLimit;
  int              idx;

  // Search upward from the pointer; a requester still holding REQ during its DONE cycle is masked.
  always_comb begin
    eligible = REQ & ~done_q;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign winVal   = REQ_VAL[int'(winner)*TW +: TW];
  assign nextPtr  = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + 1'b1;
  assign cntLimit = {1'b0, val_q} + (TW+1)'(2);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    start_d = 1'b0;
    clr_d   = 1'b0;
    err_d   = err_q;
    val_d   = val_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (SOFT_CLR) begin
      state_d = IDLE;
      gnt_d   = '0;
      err_d   = 1'b0;
      ptr_d   = '0;
      cnt_d   = '0;
      clr_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            gnt_d         = '0;
            gnt_d[winner] = 1'b1;
            val_d         = (winVal == '0) ? TW'(1) : winVal;
            start_d       = 1'b1;
            owner_d       = winner;
            state_d       = LOAD;
          end
        end
        LOAD: begin
          cnt_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          cnt_d = cnt_q + 1'b1;
          // Pulse wins over abort, abort wins over timeout.
          if (TMR_PULSE) begin
            done_d[owner_q] = 1'b1;
            gnt_d           = '0;
            ptr_d           = nextPtr;
            state_d         = IDLE;
          end else if (!REQ[owner_q]) begin
            clr_d   = 1'b1;
            gnt_d   = '0;
            ptr_d   = nextPtr;
            state_d = IDLE;
          end else if (cnt_q == cntLimit) begin
            err_d   = 1'b1;
            clr_d   = 1'b1;
            gnt_d   = '0;
            ptr_d   = nextPtr;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      val_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
      start_q <= start_d;
      clr_q   <= clr_d;
      val_q   <= val_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT       = gnt_q;
  assign DONE      = done_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign TMR_START = start_q;
  assign TMR_VAL   = val_q;
  assign TMR_CLR   = clr_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed scenarios followed by a randomized phase checked against
// a cycle-arithmetic reference model; a stub timer answers TMR_START with TMR_PULSE.
module tb_timer_sched;

  localparam int NREQ = 4;
  localparam int TW   = 21;

  logic               CLK;
  logic               RST_N;
  logic               SOFT_CLR;
  logic [NREQ-1:0]    REQ;
  logic [NREQ*TW-1:0] REQ_VAL;
  logic [NREQ-1:0]    GNT;
  logic [NREQ-1:0]    DONE;
  logic               BUSY;
  logic               ERR;
  logic               TMR_START;
  logic [TW-1:0]      TMR_VAL;
  logic               TMR_CLR;
  logic               TMR_PULSE;

  logic               timerAlive;
  logic               injectPulse;
  logic               stubPulse;
  int                 stubCnt;
  logic [32:0]        allOuts;

  int vectors;
  int miscompares;

  int          mOwner, mGntCyc, mDoneCyc, mPtr, lastVal, doneWho;
  logic [3:0]  expGnt, expDone, elig;
  logic [3:0]  order [5];
  logic [3:0]  rrExp [5];
  logic [3:0]  lastGrant, prevGnt;
  int          grants;
  logic        finished;

  timer_sched #(.NREQ(NREQ), .TW(TW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SOFT_CLR  (SOFT_CLR),
    .REQ       (REQ),
    .REQ_VAL   (REQ_VAL),
    .GNT       (GNT),
    .DONE      (DONE),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .TMR_START (TMR_START),
    .TMR_VAL   (TMR_VAL),
    .TMR_CLR   (TMR_CLR),
    .TMR_PULSE (TMR_PULSE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign allOuts   = {GNT, DONE, BUSY, ERR, TMR_START, TMR_CLR, TMR_VAL};
  assign TMR_PULSE = stubPulse | injectPulse;

  // Stub timer: START sampled with V gives a one-cycle PULSE V cycles later.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stubCnt   <= 0;
      stubPulse <= 1'b0;
    end else begin
      stubPulse <= 1'b0;
      if (TMR_CLR) stubCnt <= 0;
      else if (TMR_START && timerAlive) stubCnt <= int'(TMR_VAL);
      else if (stubCnt > 0) begin
        if (stubCnt == 1) stubPulse <= 1'b1;
        stubCnt <= stubCnt - 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic softClr);
    REQ      = req;
    SOFT_CLR = softClr;
  endtask

  task automatic setVal(input int i, input int v);
    REQ_VAL[i*TW +: TW] = TW'(v);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    RST_N = 1'b0;
    REQ_VAL = '0;
    timerAlive = 1'b1;
    injectPulse = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    tick(2);
    checkOutput("reset outputs", 64'(allOuts), 64'd0);
    RST_N = 1'b1;
    tick(1);

    // Single request, V=5; requester 0 keeps REQ through its DONE cycle.
    setVal(0, 5);
    applyStimulus(4'b0001, 1'b0);
    tick(1);
    checkOutput("t1 GNT c1", 64'(GNT), 64'h1);
    checkOutput("t1 START c1", 64'(TMR_START), 64'h1);
    checkOutput("t1 VAL c1", 64'(TMR_VAL), 64'd5);
    checkOutput("t1 BUSY c1", 64'(BUSY), 64'h1);
    tick(1);
    checkOutput("t1 START c2", 64'(TMR_START), 64'h0);
    for (int c = 2; c <= 7; c++) begin
      if (c > 2) tick(1);
      checkOutput("t1 DONE early", 64'(DONE), 64'h0);
      checkOutput("t1 GNT held", 64'(GNT), 64'h1);
    end
    tick(1);
    checkOutput("t1 DONE c8", 64'(DONE), 64'h1);
    checkOutput("t1 GNT c8", 64'(GNT), 64'h0);
    tick(1);
    checkOutput("t1 masked regrant", 64'(GNT), 64'h0);
    checkOutput("t1 DONE c9", 64'(DONE), 64'h0);
    applyStimulus(4'b0000, 1'b0);

    // Round-robin from pointer 0 with all four requesting.
    applyStimulus(4'b0000, 1'b1);
    tick(1);
    checkOutput("sclr TMR_CLR", 64'(TMR_CLR), 64'h1);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("sclr TMR_CLR gone", 64'(TMR_CLR), 64'h0);
    for (int i = 0; i < NREQ; i++) setVal(i, 2);
    rrExp[0] = 4'b0001; rrExp[1] = 4'b0010; rrExp[2] = 4'b0100;
    rrExp[3] = 4'b1000; rrExp[4] = 4'b0001;
    for (int i = 0; i < 5; i++) order[i] = 4'b0000;
    grants = 0; prevGnt = 4'b0000; lastGrant = 4'b0000; finished = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    for (int c = 0; c < 60 && !finished; c++) begin
      tick(1);
      if (GNT != 4'b0000 && prevGnt == 4'b0000 && grants < 5) begin
        order[grants] = GNT;
        lastGrant = GNT;
        grants++;
      end
      if (DONE != 4'b0000) begin
        checkOutput("rr DONE owner", 64'(DONE), 64'(lastGrant));
        if (grants == 5) begin
          finished = 1'b1;
          applyStimulus(4'b0000, 1'b0);
        end
      end
      prevGnt = GNT;
    end
    checkOutput("rr completed", 64'(finished), 64'h1);
    for (int i = 0; i < 5; i++) checkOutput("rr order", 64'(order[i]), 64'(rrExp[i]));

    // Zero interval is clamped to 1: DONE four cycles after REQ.
    tick(1);
    setVal(1, 0);
    applyStimulus(4'b0010, 1'b0);
    tick(1);
    checkOutput("t3 GNT", 64'(GNT), 64'h2);
    checkOutput("t3 VAL clamp", 64'(TMR_VAL), 64'd1);
    tick(2);
    checkOutput("t3 DONE c3", 64'(DONE), 64'h0);
    tick(1);
    checkOutput("t3 DONE c4", 64'(DONE), 64'h2);
    checkOutput("t3 ERR", 64'(ERR), 64'h0);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("t3 VAL held", 64'(TMR_VAL), 64'd1);

    // Abort of requester 2 in WAIT cycle 10; requester 3 follows.
    setVal(2, 100);
    setVal(3, 3);
    applyStimulus(4'b1100, 1'b0);
    tick(1);
    checkOutput("t4 GNT", 64'(GNT), 64'h4);
    checkOutput("t4 VAL", 64'(TMR_VAL), 64'd100);
    for (int c = 2; c <= 12; c++) begin
      tick(1);
      if (c == 5) setVal(2, 7);
      checkOutput("t4 no DONE", 64'(DONE), 64'h0);
      checkOutput("t4 GNT held", 64'(GNT), 64'h4);
    end
    checkOutput("t4 VAL stable", 64'(TMR_VAL), 64'd100);
    applyStimulus(4'b1000, 1'b0);
    tick(1);
    checkOutput("t4 TMR_CLR", 64'(TMR_CLR), 64'h1);
    checkOutput("t4 GNT dropped", 64'(GNT), 64'h0);
    checkOutput("t4 abort DONE", 64'(DONE), 64'h0);
    tick(1);
    checkOutput("t4 next GNT", 64'(GNT), 64'h8);
    checkOutput("t4 next VAL", 64'(TMR_VAL), 64'd3);
    tick(5);
    checkOutput("t4 next DONE", 64'(DONE), 64'h8);
    applyStimulus(4'b0000, 1'b0);

    // Dead timer: timeout after six WAIT cycles, then SOFT_CLR resets ERR and pointer.
    tick(1);
    timerAlive = 1'b0;
    setVal(0, 3);
    applyStimulus(4'b0001, 1'b0);
    tick(1);
    checkOutput("t5 GNT", 64'(GNT), 64'h1);
    for (int c = 2; c <= 7; c++) begin
      tick(1);
      checkOutput("t5 ERR early", 64'(ERR), 64'h0);
      checkOutput("t5 GNT held", 64'(GNT), 64'h1);
    end
    tick(1);
    checkOutput("t5 ERR", 64'(ERR), 64'h1);
    checkOutput("t5 TMR_CLR", 64'(TMR_CLR), 64'h1);
    checkOutput("t5 GNT off", 64'(GNT), 64'h0);
    checkOutput("t5 no DONE", 64'(DONE), 64'h0);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("t5 ERR sticky", 64'(ERR), 64'h1);
    applyStimulus(4'b0000, 1'b1);
    tick(1);
    checkOutput("t5 ERR cleared", 64'(ERR), 64'h0);
    checkOutput("t5 sclr TMR_CLR", 64'(TMR_CLR), 64'h1);
    timerAlive = 1'b1;
    setVal(0, 2);
    setVal(1, 2);
    applyStimulus(4'b0011, 1'b0);
    tick(1);
    checkOutput("t5 ptr reset", 64'(GNT), 64'h1);
    applyStimulus(4'b0000, 1'b0);
    tick(2);
    checkOutput("t5 abort CLR", 64'(TMR_CLR), 64'h1);
    tick(1);
    checkOutput("t5 no stale DONE", 64'(DONE), 64'h0);

    // A pulse arriving while idle is ignored.
    injectPulse = 1'b1;
    tick(1);
    injectPulse = 1'b0;
    tick(1);
    checkOutput("late pulse DONE", 64'(DONE), 64'h0);
    checkOutput("late pulse BUSY", 64'(BUSY), 64'h0);

    // Asynchronous reset mid-WAIT, then re-arbitration from requester 0.
    setVal(2, 50);
    applyStimulus(4'b0100, 1'b0);
    tick(1);
    checkOutput("t6 GNT", 64'(GNT), 64'h4);
    tick(5);
    applyStimulus(4'b0101, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("t6 async zero", 64'(allOuts), 64'd0);
    tick(1);
    checkOutput("t6 held zero", 64'(allOuts), 64'd0);
    RST_N = 1'b1;
    tick(1);
    checkOutput("t6 regrant 0", 64'(GNT), 64'h1);
    applyStimulus(4'b0000, 1'b0);
    tick(3);

    // Randomized phase against the reference model.
    applyStimulus(4'b0000, 1'b1);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    mOwner = -1; mGntCyc = 0; mDoneCyc = 0; mPtr = 0; lastVal = -1;
    for (int t = 0; t < 400; t++) begin
      tick(1);
      doneWho = -1;
      if (mOwner >= 0 && t == mDoneCyc) begin
        doneWho = mOwner;
        mPtr = (mOwner + 1) % NREQ;
        mOwner = -1;
      end
      expGnt = 4'b0000;
      if (mOwner >= 0 && t >= mGntCyc) expGnt[mOwner] = 1'b1;
      expDone = 4'b0000;
      if (doneWho >= 0) expDone[doneWho] = 1'b1;
      checkOutput("rnd GNT", 64'(GNT), 64'(expGnt));
      checkOutput("rnd DONE", 64'(DONE), 64'(expDone));
      checkOutput("rnd START", 64'(TMR_START), 64'(mOwner >= 0 && t == mGntCyc));
      checkOutput("rnd BUSY", 64'(BUSY), 64'(mOwner >= 0 && t >= mGntCyc));
      checkOutput("rnd ERR", 64'(ERR), 64'h0);
      checkOutput("rnd TMR_CLR", 64'(TMR_CLR), 64'h0);
      if (lastVal >= 0) checkOutput("rnd TMR_VAL", 64'(TMR_VAL), 64'(lastVal));
      for (int i = 0; i < NREQ; i++) begin
        if (i == mOwner) REQ[i] = 1'b1;
        else if (i == doneWho) REQ[i] = 1'($urandom_range(1));
        else if (!REQ[i]) REQ[i] = ($urandom_range(3) == 0);
        setVal(i, int'($urandom_range(6)));
      end
      if (mOwner < 0) begin
        elig = REQ;
        if (doneWho >= 0) elig[doneWho] = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          if (mOwner < 0 && elig[(mPtr + k) % NREQ]) mOwner = (mPtr + k) % NREQ;
        end
        if (mOwner >= 0) begin
          lastVal = int'(REQ_VAL[mOwner*TW +: TW]);
          if (lastVal == 0) lastVal = 1;
          mGntCyc = t + 1;
          mDoneCyc = t + 3 + lastVal;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
